// File: rtl/bht_sched_pkg.sv
// Shared types and helpers for the BHT port scheduler.
// Holds the FSM states, the update entry layout and the counter rule.
package bht_sched_pkg;

    localparam int BHT_IDX_MAX_W = 16;
    localparam int BHT_CTR_W = 2;
    localparam logic [BHT_CTR_W-1:0] BHT_INIT_CTR = 2'd1;

    typedef enum logic [1:0] {
        START,
        INIT,
        IDLE,
        UPD_WR
    } sched_state_e;

    typedef struct packed {
        logic [BHT_IDX_MAX_W-1:0] index;
        logic                     taken;
    } upd_entry_t;

    function automatic logic [BHT_CTR_W-1:0] sat_update(
        input logic [BHT_CTR_W-1:0] ctr,
        input logic                 taken
    );
        logic [BHT_CTR_W-1:0] r;
        r = ctr;
        if (taken && ctr != '1) begin
            r = ctr + 1'b1;
        end else if (!taken && ctr != '0) begin
            r = ctr - 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bht_port_scheduler_fifo.sv
// Pending branch-update buffer for the BHT port scheduler.
// Synchronous FIFO; flush empties it in one cycle.
module bht_upd_fifo
    import bht_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       push_i,
    input  upd_entry_t din_i,
    input  logic       pop_i,
    output upd_entry_t dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    upd_entry_t     r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout_o  = r_mem[r_rd_ptr];
    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/bht_port_scheduler.sv
// Single-port BHT arbiter: lookups first, buffered counter RMW updates
// in idle slots, and full-table initialisation after reset or flush.
module bht_port_scheduler
    import bht_sched_pkg::*;
#(
    parameter int NR_ENTRIES = 1024,
    parameter int CTR_W = BHT_CTR_W,
    parameter int UPD_FIFO_DEPTH = 4,
    parameter logic [CTR_W-1:0] INIT_CTR = BHT_INIT_CTR,
    localparam int INDEX_W = $clog2(NR_ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               lookup_valid_i,
    input  logic [INDEX_W-1:0] lookup_index_i,
    output logic               lookup_gnt_o,
    output logic               lookup_rvalid_o,
    output logic [CTR_W-1:0]   lookup_ctr_o,
    input  logic               upd_valid_i,
    input  logic [INDEX_W-1:0] upd_index_i,
    input  logic               upd_taken_i,
    output logic               upd_ready_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [INDEX_W-1:0] mem_addr_o,
    output logic [CTR_W-1:0]   mem_wdata_o,
    input  logic [CTR_W-1:0]   mem_rdata_i,
    output logic               busy_o,
    output logic               upd_drop_o
);

    sched_state_e       r_state;
    logic [INDEX_W-1:0] r_init_idx;
    upd_entry_t         r_pend;
    logic               r_first;
    logic [CTR_W-1:0]   r_wr_data;
    logic               r_rvalid;
    logic               r_fwd;
    logic [CTR_W-1:0]   r_fwd_data;

    upd_entry_t         w_head;
    upd_entry_t         w_push_ent;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_gnt;
    logic               w_init_wr;
    logic               w_upd_wr;
    logic               w_fwd_hit;
    logic [CTR_W-1:0]   w_new;
    logic [CTR_W-1:0]   w_wdata;

    assign w_gnt = lookup_valid_i
                 && (r_state == IDLE || r_state == UPD_WR);
    assign w_init_wr = (r_state == INIT) && !flush_i;
    assign w_upd_wr = (r_state == UPD_WR)
                    && !lookup_valid_i && !flush_i;
    assign w_pop = (r_state == IDLE) && !lookup_valid_i
                 && !w_empty && !flush_i;

    // Full FIFO still accepts when the head leaves in the same cycle.
    assign w_push = upd_valid_i && !flush_i && (!w_full || w_pop);
    assign upd_drop_o = upd_valid_i && !flush_i && w_full && !w_pop;
    assign upd_ready_o = !w_full;

    assign w_push_ent.index = BHT_IDX_MAX_W'(upd_index_i);
    assign w_push_ent.taken = upd_taken_i;

    assign w_new = sat_update(mem_rdata_i, r_pend.taken);
    assign w_wdata = r_first ? w_new : r_wr_data;
    assign w_fwd_hit = (r_state == UPD_WR) && !flush_i
                     && (BHT_IDX_MAX_W'(lookup_index_i) == r_pend.index);

    bht_upd_fifo #(
        .DEPTH(UPD_FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush_i(flush_i),
        .push_i (w_push),
        .din_i  (w_push_ent),
        .pop_i  (w_pop),
        .dout_o (w_head),
        .full_o (w_full),
        .empty_o(w_empty)
    );

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (1'b1)
            w_init_wr: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = r_init_idx;
                mem_wdata_o = INIT_CTR;
            end
            w_gnt: begin
                mem_req_o  = 1'b1;
                mem_addr_o = lookup_index_i;
            end
            w_upd_wr: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = r_pend.index[INDEX_W-1:0];
                mem_wdata_o = w_wdata;
            end
            w_pop: begin
                mem_req_o  = 1'b1;
                mem_addr_o = w_head.index[INDEX_W-1:0];
            end
            default: begin
                mem_req_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= START;
            r_init_idx <= '0;
            r_pend     <= '0;
            r_first    <= 1'b0;
            r_wr_data  <= '0;
            r_rvalid   <= 1'b0;
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_rvalid   <= w_gnt;
            r_fwd      <= w_gnt && w_fwd_hit;
            r_fwd_data <= w_wdata;
            if (flush_i) begin
                r_state    <= START;
                r_init_idx <= '0;
                r_first    <= 1'b0;
            end else begin
                unique case (r_state)
                    START: r_state <= INIT;
                    INIT: begin
                        r_init_idx <= r_init_idx + 1'b1;
                        if (&r_init_idx) begin
                            r_state <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (w_pop) begin
                            r_pend  <= w_head;
                            r_first <= 1'b1;
                            r_state <= UPD_WR;
                        end
                    end
                    UPD_WR: begin
                        r_first <= 1'b0;
                        if (r_first) begin
                            r_wr_data <= w_new;
                        end
                        if (!lookup_valid_i) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= START;
                endcase
            end
        end
    end

    assign busy_o = (r_state == START) || (r_state == INIT);
    assign lookup_gnt_o = w_gnt;
    assign lookup_rvalid_o = r_rvalid;
    assign lookup_ctr_o = !r_rvalid ? '0
                        : (r_fwd ? r_fwd_data : mem_rdata_i);

endmodule

// File: tb/tb_bht_port_scheduler.sv
// Bench for bht_port_scheduler: directed scenarios plus random traffic
// against a cycle-level behavioural model of the port schedule.
module tb_bht_port_scheduler;

    localparam int N = 16;
    localparam int IW = 4;
    localparam int DEPTH = 4;
    localparam int INIT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_ni;
    logic          fl;
    logic          lv;
    logic [IW-1:0] li;
    logic          gnt;
    logic          rvalid;
    logic [1:0]    rctr;
    logic          uv;
    logic [IW-1:0] ui;
    logic          ut;
    logic          uready;
    logic          mreq;
    logic          mwe;
    logic [IW-1:0] maddr;
    logic [1:0]    mwdata;
    logic [1:0]    mrdata = 2'd0;
    logic          busy;
    logic          drop;

    logic [1:0] mem [N] = '{3, 0, 2, 3, 0, 2, 3, 0,
                            2, 3, 0, 2, 3, 0, 2, 3};

    bht_port_scheduler #(
        .NR_ENTRIES(N)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (fl),
        .lookup_valid_i (lv),
        .lookup_index_i (li),
        .lookup_gnt_o   (gnt),
        .lookup_rvalid_o(rvalid),
        .lookup_ctr_o   (rctr),
        .upd_valid_i    (uv),
        .upd_index_i    (ui),
        .upd_taken_i    (ut),
        .upd_ready_o    (uready),
        .mem_req_o      (mreq),
        .mem_we_o       (mwe),
        .mem_addr_o     (maddr),
        .mem_wdata_o    (mwdata),
        .mem_rdata_i    (mrdata),
        .busy_o         (busy),
        .upd_drop_o     (drop)
    );

    // Counter array behind the port.
    always @(posedge clk) begin
        if (mreq) begin
            if (mwe) mem[maddr] <= mwdata;
            else     mrdata <= mem[maddr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int msat(input int c, input bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    typedef struct {
        int idx;
        bit tk;
    } ment_t;

    // Model: m_k counts cycles since reset/flush (0 = quiet cycle,
    // 1..N = init writes); m_ctr holds the logical counter values.
    int    m_k;
    ment_t m_q[$];
    ment_t ent;
    bit    m_pend;
    int    m_pidx;
    int    m_pold;
    int    m_ctr [N];
    bit    e_rv;
    int    e_val;
    bit    x_full, x_busy, x_gnt, x_req, x_we, x_drop, popped, n_rv;
    int    x_addr, x_wdata, n_val;

    always @(negedge clk) begin
        if (!rst_ni) begin
            m_k = 0;
            m_q.delete();
            m_pend = 0;
            e_rv = 0;
            e_val = 0;
            foreach (m_ctr[i]) m_ctr[i] = INIT;
        end else begin
            chk("rvalid", rvalid, e_rv);
            if (e_rv) chk("lookup_ctr", rctr, e_val);
            x_full = (m_q.size() == DEPTH);
            popped = 0;
            n_rv = 0;
            n_val = 0;
            x_we = 0;
            x_addr = 0;
            x_wdata = 0;
            if (m_k <= N) begin
                x_busy = 1;
                x_gnt = 0;
                x_req = (m_k != 0) && !fl;
                x_we = x_req;
                x_addr = m_k - 1;
                x_wdata = INIT;
            end else begin
                x_busy = 0;
                x_gnt = lv;
                if (lv) begin
                    x_req = 1;
                    x_addr = li;
                    n_rv = 1;
                    if (fl && m_pend && int'(li) == m_pidx) n_val = m_pold;
                    else n_val = m_ctr[li];
                end else if (m_pend && !fl) begin
                    x_req = 1;
                    x_we = 1;
                    x_addr = m_pidx;
                    x_wdata = m_ctr[m_pidx];
                    m_pend = 0;
                end else if (!m_pend && m_q.size() > 0 && !fl) begin
                    x_req = 1;
                    ent = m_q.pop_front();
                    x_addr = ent.idx;
                    m_pend = 1;
                    m_pidx = ent.idx;
                    m_pold = m_ctr[ent.idx];
                    m_ctr[ent.idx] = msat(m_pold, ent.tk);
                    popped = 1;
                end else begin
                    x_req = 0;
                end
            end
            x_drop = uv && x_full && !popped && !fl;
            chk("busy", busy, x_busy);
            chk("gnt", gnt, x_gnt);
            chk("mem_req", mreq, x_req);
            if (x_req) begin
                chk("mem_we", mwe, x_we);
                chk("mem_addr", maddr, x_addr);
                if (x_we) chk("mem_wdata", mwdata, x_wdata);
            end
            chk("upd_ready", uready, !x_full);
            chk("upd_drop", drop, x_drop);
            if (uv && !fl && (!x_full || popped)) begin
                ent.idx = ui;
                ent.tk = ut;
                m_q.push_back(ent);
            end
            if (fl) begin
                m_k = 0;
                m_q.delete();
                m_pend = 0;
                foreach (m_ctr[i]) m_ctr[i] = INIT;
            end else if (m_k <= N) begin
                m_k++;
            end
            e_rv = n_rv;
            e_val = n_val;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 1;
        #1;
        while (busy && n < 200) begin
            tick();
            #1;
            n++;
        end
    endtask

    task automatic push_upd(input int idx, input bit t);
        uv = 1;
        ui = IW'(idx);
        ut = t;
        tick();
        uv = 0;
    endtask

    int nb;
    int lp;
    int exp5 [7] = '{2, 3, 3, 2, 1, 0, 0};

    initial begin
        rst_ni = 0;
        fl = 0;
        lv = 0;
        li = '0;
        uv = 0;
        ui = '0;
        ut = 0;
        tick();
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_req", mreq, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_ctr", rctr, 0);
        chk("rst_ready", uready, 1);
        chk("rst_drop", drop, 0);
        tick();
        rst_ni = 1;
        count_busy(nb);
        chk("busy_len_reset", nb, 18);

        // Lookup forwarded from the in-flight update of index 7.
        push_upd(7, 1);
        tick();
        lv = 1;
        li = 4'd7;
        tick();
        li = 4'd3;
        #1;
        chk("fwd_same_idx", rctr, 2);
        tick();
        lv = 0;
        #1;
        chk("fwd_other_idx", rctr, 1);
        repeat (3) tick();
        chk("fwd_written", mem[7], 2);

        for (int i = 0; i < 7; i++) begin
            push_upd(5, i < 3);
            repeat (3) tick();
            chk("ctr5_step", mem[5], exp5[i]);
        end

        lv = 1;
        li = 4'd0;
        for (int i = 0; i < 5; i++) begin
            uv = 1;
            ui = IW'(8 + i);
            ut = 1;
            #1;
            if (i == 4) begin
                chk("ready_full", uready, 0);
                chk("drop_full", drop, 1);
            end
            tick();
        end
        uv = 0;
        repeat (6) tick();
        lv = 0;
        repeat (12) tick();
        for (int i = 0; i < 4; i++) chk("fifo_applied", mem[8 + i], 2);
        chk("fifo_dropped", mem[12], 1);

        fl = 1;
        tick();
        fl = 0;
        repeat (10) tick();
        #1;
        chk("init_addr9", maddr, 9);
        chk("init_we9", mwe, 1);
        fl = 1;
        tick();
        fl = 0;
        count_busy(nb);
        chk("busy_len_flush", nb, 18);

        uv = 1;
        ui = 4'd13;
        ut = 1;
        tick();
        ui = 4'd14;
        tick();
        ui = 4'd15;
        fl = 1;
        #1;
        chk("flush_updwr_req", mreq, 0);
        chk("flush_no_drop", drop, 0);
        tick();
        uv = 0;
        fl = 0;
        #1;
        chk("flush_busy", busy, 1);
        chk("flush_ready", uready, 1);
        count_busy(nb);
        chk("busy_len_flush2", nb, 18);
        repeat (5) tick();
        chk("abandoned_13", mem[13], 1);
        chk("cleared_14", mem[14], 1);

        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) lp = $urandom_range(80, 5);
            lv = ($urandom_range(99, 0) < lp);
            li = IW'($urandom_range(N - 1, 0));
            uv = ($urandom_range(1, 0) == 1);
            ui = IW'($urandom_range(N - 1, 0));
            ut = ($urandom_range(1, 0) == 1);
            fl = ($urandom_range(399, 0) == 0);
            tick();
        end
        lv = 0;
        uv = 0;
        fl = 0;
        repeat (40) tick();
        chk("drained_busy", busy, 0);
        for (int i = 0; i < N; i++) chk("final_mem", mem[i], m_ctr[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
